display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scanner for a common-anode 7-segment
// bank. Each digit slot ends with a blanking gap, lit time is gated by a
// global PWM brightness, and host-written shadow codes reach the displayed
// set only on a frame boundary so a frame never mixes old and new digits.
module display_scan_ctrl #(
    parameter int NUM_DIGITS       = 5,
    parameter int CYCLES_PER_DIGIT = 83333,
    parameter int BLANK_CYCLES     = 2500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [4:0]            wr_data,
    input  logic                  commit_req,
    input  logic [3:0]            brightness,
    output logic                  commit_ack,
    output logic                  frame_start,
    output logic [2:0]            digit_sel,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg
);

    localparam int              CW         = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
    localparam logic [CW-1:0]   LAST_CNT   = CW'(CYCLES_PER_DIGIT - 1);
    // One extra bit so a slot with no blanking gap still compares correctly.
    localparam logic [CW:0]     ACTIVE_END = (CW+1)'(CYCLES_PER_DIGIT - BLANK_CYCLES);
    localparam logic [2:0]      LAST_DIG   = 3'(NUM_DIGITS - 1);
    localparam logic [4:0]      BLANK_CODE = 5'h10;
    localparam logic [6:0]      SEG_OFF    = 7'h7F;

    typedef enum logic {
        ACTIVE = 1'b0,
        BLANK  = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [2:0]            dig, dig_next;
    logic [3:0]            pwm_cnt, pwm_next;
    logic                  slot_wrap, frame_wrap;
    logic                  commit_pending;
    logic [4:0]            shadow [NUM_DIGITS];
    logic [4:0]            disp   [NUM_DIGITS];
    logic [4:0]            entry;
    logic                  lit;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [6:0]            seg_next;

    // Active-low gfedcba pattern for a hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // Next slot counter, digit index, ACTIVE/BLANK state and PWM phase.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        slot_wrap  = (cnt == LAST_CNT);
        frame_wrap = slot_wrap && (dig == LAST_DIG);
        cnt_next   = slot_wrap ? '0 : cnt + CW'(1);
        dig_next   = dig;
        state_next = state;
        pwm_next   = pwm_cnt;
        if (slot_wrap) begin
            dig_next = frame_wrap ? 3'd0 : dig + 3'd1;
        end
        case (state)
            ACTIVE: begin
                pwm_next = pwm_cnt + 4'd1;
                if (!slot_wrap && ({1'b0, cnt_next} >= ACTIVE_END)) begin
                    state_next = BLANK;
                end
            end
            BLANK: begin
                if (slot_wrap) begin
                    state_next = ACTIVE;
                end
            end
            default: state_next = ACTIVE;
        endcase
        // Every slot starts a fresh PWM period.
        if (slot_wrap) begin
            pwm_next = 4'd0;
        end
    end

    // Pin values for the current scan position; registered on the next edge.
    always_comb begin
        entry      = BLANK_CODE;
        anode_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig == 3'(i)) begin
                entry = disp[i];
            end
        end
        lit      = (state == ACTIVE) && !entry[4] && (pwm_cnt <= brightness);
        seg_next = ((state == ACTIVE) && !entry[4]) ? hex_to_seg(entry[3:0]) : SEG_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig == 3'(i)) begin
                anode_next[i] = ~lit;
            end
        end
    end

    // Scan position, FSM state and PWM phase registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
        if (reset) begin
            state   <= ACTIVE;
            cnt     <= '0;
            dig     <= 3'd0;
            pwm_cnt <= 4'd0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            dig     <= dig_next;
            pwm_cnt <= pwm_next;
        end
    end

    // Registered pin drivers: one cycle behind the scan position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_sel   <= 3'd0;
            anode       <= '1;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            digit_sel   <= dig;
            anode       <= anode_next;
            seg         <= seg_next;
            frame_start <= frame_wrap;
        end
    end

    // Shadow writes and the frame-boundary copy into the displayed set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_pending <= 1'b0;
            commit_ack     <= 1'b0;
            // NOTE: the digit arrays are small flop banks rather than RAM, so they take a reset value like any register.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= BLANK_CODE;
                disp[i]   <= BLANK_CODE;
            end
        end else begin
            // Only a request already pending before the boundary is served;
            // one arriving in the boundary cycle waits for the next frame.
            commit_ack <= frame_wrap && commit_pending;
            if (frame_wrap) begin
                commit_pending <= commit_req;
            end else begin
                commit_pending <= commit_pending | commit_req;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (frame_wrap && commit_pending) begin
                    disp[i] <= shadow[i];
                end
                // Out-of-range addresses match no entry and are dropped.
                if (wr_en && (wr_addr == 3'(i))) begin
                    shadow[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl (5 digits, 20 cycles per slot, 4 blank).
// The stimulus process pushes one expected-frame record per frame; the
// monitor pops a record at each frame_start and scores the 100 cycles that
// follow: commit_ack, per-digit segments, per-digit lit cycles, and timing.
module tb_display_scan_ctrl;

    localparam int ND = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [4:0]    wr_data;
    logic          commit_req;
    logic [3:0]    brightness;
    logic          commit_ack;
    logic          frame_start;
    logic [2:0]    digit_sel;
    logic [ND-1:0] anode;
    logic [6:0]    seg;

    display_scan_ctrl #(
        .NUM_DIGITS      (ND),
        .CYCLES_PER_DIGIT(20),
        .BLANK_CYCLES    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit_req (commit_req),
        .brightness (brightness),
        .commit_ack (commit_ack),
        .frame_start(frame_start),
        .digit_sel  (digit_sel),
        .anode      (anode),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ack;
        logic [6:0] seg [ND];
        int         lit [ND];
    } frame_t;

    frame_t exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int frames_pushed = 0;
    int frames_done = 0;
    int pos = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // segs packs digit 0 in the top seven bits; an all-off digit is never lit.
    function automatic frame_t mk_frame(input logic ack, input logic [34:0] segs, input int on_cycles);
        frame_t f;
        f.ack = ack;
        for (int i = 0; i < ND; i++) begin
            f.seg[i] = segs[34 - 7*i -: 7];
            f.lit[i] = (f.seg[i] == 7'h7F) ? 0 : on_cycles;
        end
        return f;
    endfunction

    task automatic push(input frame_t f);
        exp_q.push_back(f);
        frames_pushed++;
    endtask

    task automatic step();
        @(negedge clk);
        pos++;
    endtask

    task automatic goto_pos(input int p);
        while (pos < p) step();
    endtask

    task automatic next_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 150);
        if (!frame_start) check("stim_frame_start_timeout", n, 100);
        pos = 0;
    endtask

    task automatic write(input logic [2:0] a, input logic [4:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_commit();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
    endtask

    // From reset release: everything dark until the first frame_start, which
    // must arrive exactly 100 cycles later.
    task automatic pre_frame_check(input string name);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (anode != 5'h1F || seg != 7'h7F) bad++;
        end while (!frame_start && n < 150);
        check({name, "_first_frame_cycle"}, n, 100);
        check({name, "_dark_cycles"}, bad, 0);
        pos = 0;
    endtask

    localparam logic [34:0] ALL_DARK  = {5{7'h7F}};
    localparam logic [34:0] ALL_EIGHT = {5{7'h00}};

    initial begin : stimulus
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 5'd0;
        commit_req = 1'b0;
        brightness = 4'd15;
        push(mk_frame(1'b0, ALL_DARK, 16));                                   // F1
        repeat (3) @(posedge clk);
        #1;
        check("reset_anode", anode, 5'h1F);
        check("reset_seg", seg, 7'h7F);
        check("reset_digit_sel", digit_sel, 0);
        check("reset_commit_ack", commit_ack, 0);
        check("reset_frame_start", frame_start, 0);
        @(negedge clk);
        reset = 1'b0;
        pre_frame_check("startup");

        // F1: load 1..5 and commit.
        push(mk_frame(1'b1, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 16));        // F2
        for (int i = 0; i < ND; i++) write(3'(i), 5'(i + 1));
        pulse_commit();
        next_frame();

        // F2: all eights, shown next frame at brightness 3.
        push(mk_frame(1'b1, ALL_EIGHT, 4));                                   // F3
        for (int i = 0; i < ND; i++) write(3'(i), 5'h08);
        pulse_commit();
        next_frame();

        // F3
        brightness = 4'd3;
        push(mk_frame(1'b0, ALL_EIGHT, 16));                                  // F4
        next_frame();

        // F4: full brightness; write digit 0 = 7 without committing.
        brightness = 4'd15;
        push(mk_frame(1'b0, ALL_EIGHT, 16));                                  // F5
        write(3'd0, 5'h07);
        next_frame();
        push(mk_frame(1'b0, ALL_EIGHT, 16));                                  // F6
        next_frame();
        push(mk_frame(1'b0, ALL_EIGHT, 16));                                  // F7
        next_frame();

        // F7: commit the pending 7.
        push(mk_frame(1'b1, {7'h78, 7'h00, 7'h00, 7'h00, 7'h00}, 16));        // F8
        pulse_commit();
        next_frame();

        // F8: out-of-range writes, then request + write in the boundary cycle.
        push(mk_frame(1'b0, {7'h78, 7'h00, 7'h00, 7'h00, 7'h00}, 16));        // F9
        write(3'd6, 5'h03);
        write(3'd7, 5'h04);
        goto_pos(99);
        commit_req = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 3'd1;
        wr_data    = 5'h0A;
        next_frame();
        commit_req = 1'b0;
        wr_en      = 1'b0;

        // F9: the deferred commit lands at the next boundary.
        push(mk_frame(1'b1, {7'h78, 7'h08, 7'h00, 7'h00, 7'h00}, 16));        // F10
        next_frame();

        // F10: blank digit 3, F on digit 4, two requests merge into one commit.
        push(mk_frame(1'b1, {7'h78, 7'h08, 7'h00, 7'h7F, 7'h0E}, 16));        // F11
        write(3'd3, 5'h10);
        write(3'd4, 5'h0F);
        pulse_commit();
        repeat (3) step();
        pulse_commit();
        next_frame();
        push(mk_frame(1'b0, {7'h78, 7'h08, 7'h00, 7'h7F, 7'h0E}, 16));        // F12
        next_frame();

        // F12: reset mid-slot of digit 2 with a commit pending.
        goto_pos(50);
        commit_req = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 3'd0;
        wr_data    = 5'h01;
        step();
        commit_req = 1'b0;
        wr_en      = 1'b0;
        goto_pos(52);
        check("pre_reset_anode", anode, 5'b11011);
        #2 reset = 1'b1;
        #1;
        check("async_reset_anode", anode, 5'h1F);
        check("async_reset_seg", seg, 7'h7F);
        check("async_reset_commit_ack", commit_ack, 0);
        repeat (3) @(negedge clk);
        frames_pushed -= exp_q.size();
        exp_q.delete();
        push(mk_frame(1'b0, ALL_DARK, 16));
        push(mk_frame(1'b0, ALL_DARK, 16));
        reset = 1'b0;
        pre_frame_check("post_reset");
        next_frame();

        begin
            int n;
            n = 0;
            while (frames_done < frames_pushed && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (frames_done < frames_pushed) check("scoreboard_drain", frames_done, frames_pushed);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : monitor
        frame_t     rec;
        int         miss;
        int         struct_bad;
        int         d;
        int         c;
        bit         aborted;
        int         lit_cnt [ND];
        logic [6:0] seg_seen [ND];
        logic [4:0] on_pat;
        forever begin
            miss = 0;
            do begin
                @(negedge clk);
                if (!reset) miss++;
                if (miss > 150) begin
                    check("monitor_frame_start_timeout", miss, 100);
                    miss = 0;
                end
            end while (!(frame_start && !reset));
            while (exp_q.size() > 0) begin
                rec = exp_q.pop_front();
                check("commit_ack", commit_ack, rec.ack);
                aborted    = 1'b0;
                struct_bad = 0;
                for (int i = 0; i < ND; i++) begin
                    lit_cnt[i]  = 0;
                    seg_seen[i] = rec.seg[i];
                end
                for (int j = 0; j < 100; j++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    d      = j / 20;
                    c      = j % 20;
                    on_pat = ~(5'(1) << d);
                    if (digit_sel != 3'(d)) struct_bad++;
                    if (frame_start != (j == 99)) struct_bad++;
                    if (j < 99 && commit_ack) struct_bad++;
                    if (c < 16) begin
                        if (anode == on_pat) lit_cnt[d]++;
                        else if (anode != 5'h1F) struct_bad++;
                        if (seg != rec.seg[d]) seg_seen[d] = seg;
                    end else if (anode != 5'h1F || seg != 7'h7F) begin
                        struct_bad++;
                    end
                end
                frames_done++;
                if (aborted) break;
                for (int i = 0; i < ND; i++) begin
                    check($sformatf("seg_digit%0d", i), seg_seen[i], rec.seg[i]);
                    check($sformatf("lit_cycles_digit%0d", i), lit_cnt[i], rec.lit[i]);
                end
                check("frame_timing_errors", struct_bad, 0);
                if (!frame_start) break;
            end
        end
    end

endmodule
